// File: rtl/serial_rx_shifter.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB-first,
// optional even parity and a stop bit, with one-cycle valid/error strobes.
module serial_rx_shifter #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Din,
  output logic [WIDTH-1:0] Data,
  output logic             Valid,
  output logic             ParityErr,
  output logic             FrameErr,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BRK    = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             par;

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      Data      <= '0;
      Valid     <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      Valid     <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (!Din) begin
            state <= DATA;
            cnt   <= '0;
            par   <= 1'b0;
          end
        end
        DATA: begin
          // Right shift so the first (LSB) bit ends at bit 0 after WIDTH shifts
          shreg <= {Din, shreg[WIDTH-1:1]};
          par   <= par ^ Din;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par   <= par ^ Din;
          state <= STOP;
        end
        STOP: begin
          if (Din) begin
            Data      <= shreg;
            Valid     <= 1'b1;
            ParityErr <= (PARITY_EN != 0) && par;
            state     <= IDLE;
          end else begin
            FrameErr <= 1'b1;
            state    <= BRK;
          end
        end
        BRK: begin
          // The line must return high before a new start bit is honoured
          if (Din) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_shifter.sv
// Directed bench for serial_rx_shifter: one parity-enabled and one
// parity-disabled instance driven by hand-built frames.
module tb_serial_rx_shifter;

  logic       clk;
  logic       rst_n;
  logic       din_a;
  logic       din_b;
  logic [7:0] data_a;
  logic       valid_a, perr_a, ferr_a, busy_a;
  logic [7:0] data_b;
  logic       valid_b, perr_b, ferr_b, busy_b;

  int pass_cnt;
  int total_cnt;

  serial_rx_shifter #(.WIDTH(8), .PARITY_EN(1)) dut_a (
    .Clock    (clk),
    .Resetn   (rst_n),
    .Din      (din_a),
    .Data     (data_a),
    .Valid    (valid_a),
    .ParityErr(perr_a),
    .FrameErr (ferr_a),
    .Busy     (busy_a)
  );

  serial_rx_shifter #(.WIDTH(8), .PARITY_EN(0)) dut_b (
    .Clock    (clk),
    .Resetn   (rst_n),
    .Din      (din_b),
    .Data     (data_b),
    .Valid    (valid_b),
    .ParityErr(perr_b),
    .FrameErr (ferr_b),
    .Busy     (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit_a(input logic b);
    din_a = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit_b(input logic b);
    din_b = b;
    @(posedge clk);
    #1;
  endtask

  // Everything up to, but not including, the stop bit
  task automatic send_body_a(input logic [7:0] d, input logic p);
    send_bit_a(1'b0);
    for (int i = 0; i < 8; i++) send_bit_a(d[i]);
    send_bit_a(p);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din_a = 1'b1;
    din_b = 1'b1;
    #3;
    total_cnt++;
    if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h000)
      $display("FAIL reset_a: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               data_a, valid_a, perr_a, ferr_a, busy_a);
    else pass_cnt++;
    total_cnt++;
    if ({data_b, valid_b, perr_b, ferr_b, busy_b} !== 12'h000)
      $display("FAIL reset_b: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               data_b, valid_b, perr_b, ferr_b, busy_b);
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_bit_a(1'b1);
    send_bit_a(1'b1);
  endtask

  task automatic test_good_frame;
    send_body_a(8'hA5, 1'b0);
    total_cnt++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL good_before_stop: valid=%b busy=%b, want valid=0 busy=1", valid_a, busy_a);
    else pass_cnt++;
    send_bit_a(1'b1);
    total_cnt++;
    if (valid_a !== 1'b1 || data_a !== 8'hA5)
      $display("FAIL good_valid: valid=%b data=%h, want valid=1 data=a5", valid_a, data_a);
    else pass_cnt++;
    total_cnt++;
    if (perr_a !== 1'b0 || ferr_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL good_flags: pe=%b fe=%b busy=%b, want 0 0 0", perr_a, ferr_a, busy_a);
    else pass_cnt++;
    send_bit_a(1'b1);
    total_cnt++;
    if (valid_a !== 1'b0 || data_a !== 8'hA5)
      $display("FAIL good_pulse_end: valid=%b data=%h, want valid=0 data=a5", valid_a, data_a);
    else pass_cnt++;
  endtask

  task automatic test_parity_err;
    send_body_a(8'h01, 1'b0);
    send_bit_a(1'b1);
    total_cnt++;
    if (valid_a !== 1'b1 || data_a !== 8'h01 || perr_a !== 1'b1 || ferr_a !== 1'b0)
      $display("FAIL parity_err: valid=%b data=%h pe=%b fe=%b, want 1 01 1 0",
               valid_a, data_a, perr_a, ferr_a);
    else pass_cnt++;
    send_bit_a(1'b1);
    total_cnt++;
    if (valid_a !== 1'b0 || perr_a !== 1'b0)
      $display("FAIL parity_clear: valid=%b pe=%b, want 0 0", valid_a, perr_a);
    else pass_cnt++;
  endtask

  task automatic test_frame_err;
    send_body_a(8'hA5, 1'b0);
    send_bit_a(1'b1);
    send_bit_a(1'b1);
    send_body_a(8'h3C, 1'b0);
    send_bit_a(1'b0);
    total_cnt++;
    if (ferr_a !== 1'b1 || valid_a !== 1'b0 || data_a !== 8'hA5 || busy_a !== 1'b1)
      $display("FAIL frame_err: fe=%b valid=%b data=%h busy=%b, want 1 0 a5 1",
               ferr_a, valid_a, data_a, busy_a);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      send_bit_a(1'b0);
      total_cnt++;
      if (ferr_a !== 1'b0 || busy_a !== 1'b1 || valid_a !== 1'b0)
        $display("FAIL break_hold[%0d]: fe=%b busy=%b valid=%b, want 0 1 0",
                 i, ferr_a, busy_a, valid_a);
      else pass_cnt++;
    end
    send_bit_a(1'b1);
    total_cnt++;
    if (busy_a !== 1'b0 || data_a !== 8'hA5)
      $display("FAIL break_exit: busy=%b data=%h, want 0 a5", busy_a, data_a);
    else pass_cnt++;
    send_bit_a(1'b1);
  endtask

  task automatic test_back_to_back;
    logic       bits [22];
    logic [7:0] d0, d1;
    int         n_pulse;
    int         idx [2];
    logic [7:0] got [2];
    d0 = 8'h12;
    d1 = 8'h34;
    bits[0] = 1'b0;
    bits[11] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bits[1 + i]  = d0[i];
      bits[12 + i] = d1[i];
    end
    bits[9]  = 1'b0;  // 0x12 has two ones
    bits[10] = 1'b1;
    bits[20] = 1'b1;  // 0x34 has three ones
    bits[21] = 1'b1;
    n_pulse = 0;
    idx[0] = -1; idx[1] = -1;
    got[0] = 8'h00; got[1] = 8'h00;
    for (int i = 0; i < 22; i++) begin
      send_bit_a(bits[i]);
      if (valid_a === 1'b1) begin
        if (n_pulse < 2) begin
          idx[n_pulse] = i;
          got[n_pulse] = data_a;
        end
        n_pulse++;
      end
    end
    total_cnt++;
    if (n_pulse !== 2 || idx[1] - idx[0] !== 11)
      $display("FAIL b2b_timing: pulses=%0d at %0d,%0d, want 2 pulses 11 apart",
               n_pulse, idx[0], idx[1]);
    else pass_cnt++;
    total_cnt++;
    if (got[0] !== 8'h12 || got[1] !== 8'h34)
      $display("FAIL b2b_data: got %h,%h want 12,34", got[0], got[1]);
    else pass_cnt++;
    send_bit_a(1'b1);
  endtask

  task automatic test_reset_mid;
    send_bit_a(1'b0);
    for (int i = 0; i < 4; i++) send_bit_a(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h000)
      $display("FAIL reset_mid: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               data_a, valid_a, perr_a, ferr_a, busy_a);
    else pass_cnt++;
    din_a = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_bit_a(1'b1);
    send_bit_a(1'b1);
    total_cnt++;
    if (busy_a !== 1'b0)
      $display("FAIL reset_mid_idle: busy=%b want 0", busy_a);
    else pass_cnt++;
    send_body_a(8'h5A, 1'b0);
    send_bit_a(1'b1);
    total_cnt++;
    if (valid_a !== 1'b1 || data_a !== 8'h5A || perr_a !== 1'b0 || ferr_a !== 1'b0)
      $display("FAIL reset_mid_frame: valid=%b data=%h pe=%b fe=%b, want 1 5a 0 0",
               valid_a, data_a, perr_a, ferr_a);
    else pass_cnt++;
    send_bit_a(1'b1);
  endtask

  task automatic test_idle_no_parity;
    int         bad;
    logic [7:0] d;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      send_bit_b(1'b1);
      if (valid_b !== 1'b0 || busy_b !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL idle_quiet: %0d cycles with valid/busy set, want 0", bad);
    else pass_cnt++;
    d = 8'hFF;
    send_bit_b(1'b0);
    for (int i = 0; i < 8; i++) send_bit_b(d[i]);
    total_cnt++;
    if (valid_b !== 1'b0 || busy_b !== 1'b1)
      $display("FAIL nopar_before_stop: valid=%b busy=%b, want 0 1", valid_b, busy_b);
    else pass_cnt++;
    send_bit_b(1'b1);
    total_cnt++;
    if (valid_b !== 1'b1 || data_b !== 8'hFF || perr_b !== 1'b0 || ferr_b !== 1'b0)
      $display("FAIL nopar_frame: valid=%b data=%h pe=%b fe=%b, want 1 ff 0 0",
               valid_b, data_b, perr_b, ferr_b);
    else pass_cnt++;
    send_bit_b(1'b1);
    total_cnt++;
    if (valid_b !== 1'b0)
      $display("FAIL nopar_pulse_end: valid=%b want 0", valid_b);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_idle_no_parity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_rx_shifter.md
# serial_rx_shifter

Serial-to-parallel frame receiver on the D-flip-flop-based datapath. It consumes the single synchronized serial bit produced by the upstream flip-flop stage, one bit per `Clock`. It detects a start bit and shifts in `WIDTH` data bits LSB-first, optionally checks even parity, and checks the stop bit. It then presents the assembled word with a one-cycle valid strobe and error flags.

## Interface
- `WIDTH`, default 8: data bits per frame, legal range 2–16.
- `PARITY_EN`, default 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
- `Clock`  input  1  rising-edge clock. One serial bit is sampled per edge.
- `Resetn`  input  1  asynchronous, active-low reset. This is decided: one clock, asynchronous active-low reset.
- `Din`  input  1  serial line, already synchronized to `Clock` upstream. Idle level is 1.
- `Data`  output  WIDTH  last correctly framed word, held until the next one.
- `Valid`  output  1  one-cycle pulse: `Data` was updated this cycle.
- `ParityErr`  output  1  qualifies `Valid`: the received parity bit was wrong.
- `FrameErr`  output  1  one-cycle pulse: stop bit sampled as 0.
- `Busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Frame on `Din`: start bit (0), then `WIDTH` data bits LSB-first, then the parity bit if `PARITY_EN`, then the stop bit (1).
- Frame length is `WIDTH+2+PARITY_EN` clocks.
- Even parity: the data bits plus the parity bit contain an even number of ones.
- States and transitions:
  - IDLE: on `Din`=0, go to DATA and clear the bit counter and the parity accumulator. On `Din`=1, stay in IDLE.
  - DATA: on each edge, shift `Din` into the MSB of the shift register (right shift), XOR `Din` into the parity accumulator, and increment the counter. After `WIDTH` bits, go to PARITY if `PARITY_EN`, else go to STOP.
  - PARITY: XOR `Din` into the accumulator, then go to STOP.
  - STOP, with `Din`=1:
    - Load `Data` from the shift register.
    - Set `Valid`=1.
    - Set `ParityErr` = accumulator, or 0 when `PARITY_EN`=0.
    - Go to IDLE.
  - STOP, with `Din`=0: set `FrameErr`=1, leave `Data` unchanged, keep `Valid`=0, and go to BREAK.
  - BREAK: stay while `Din`=0. On `Din`=1, go to IDLE. A start bit is not accepted until the line has been seen high.
- `Valid`, `ParityErr` and `FrameErr` are registered. They are high for exactly one cycle, then return to 0.
- A frame with a bad parity bit but a good stop bit still delivers `Data`: `Valid`=1 and `ParityErr`=1.
- The bit counter is `$clog2(WIDTH+1)` bits wide. No counter wraps within a frame.
- `Busy` is combinational from the state: it equals (state != IDLE).
- Reset:
  - `Resetn`=0 asynchronously forces IDLE.
  - `Data`=0, `Valid`=0, `ParityErr`=0, `FrameErr`=0, `Busy`=0.
  - The shift register, counter and accumulator are cleared.
  - Reset mid-frame discards the partial frame. After release, the receiver waits for a fresh start bit.

## Timing
- Edge 0 samples the start bit. Edges 1..`WIDTH` sample data. Edge `WIDTH+1` samples parity (when `PARITY_EN`=1). The last edge samples the stop bit.
- `Valid` or `FrameErr` is high during the cycle after the stop-bit edge. Latency is `WIDTH+2+PARITY_EN` edges from the start edge.
- Back-to-back frames: the FSM is in IDLE in the `Valid` cycle. If `Din`=0 on that edge, it is taken as the next start bit, giving zero idle bits between frames.
- `Busy` rises in the cycle after the start edge and falls in the `Valid` cycle, or in the cycle after BREAK sees `Din`=1.
- `Resetn` deassertion is synchronous to the next rising `Clock`. The first start bit can be sampled on that edge.

## Test plan
- Good frame, `WIDTH`=8, `PARITY_EN`=1: send start, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 1. Required response: `Valid`=1 for one cycle, 11 edges after the start edge, with `Data`=0xA5, `ParityErr`=0, `FrameErr`=0.
- Parity error: send 0x01 with parity bit 0. Required response: `Valid`=1, `Data`=0x01, `ParityErr`=1. Both flags are 0 on the next cycle.
- Framing error: after 0xA5 has been received, send 0x3C with stop bit 0, then hold `Din`=0 for 5 cycles, then 1.
  - `FrameErr` pulses for one cycle, `Valid` stays 0, and `Data` remains 0xA5.
  - `Busy` stays 1 until the cycle after `Din` returns to 1.
- Back-to-back: send 0x12 then 0x34 with no idle bits between them. Required response: two `Valid` pulses exactly 11 cycles apart, with `Data`=0x12 then 0x34.
- Reset mid-frame: assert `Resetn`=0 after 4 data bits have been received.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - A following full 0x5A frame gives `Data`=0x5A with no error flags.
- Idle and `PARITY_EN`=0: with `Din` held at 1 for 100 cycles, there is no `Valid` and `Busy`=0. Then, with `PARITY_EN`=0, send 0xFF. Required response: `Valid` 10 edges after the start edge, `Data`=0xFF, `ParityErr`=0.
